// File: rtl/tmnt_rom_pkg.sv
// Shared types, default SDRAM base addresses and byte-address forming
// for the TMNT ROM fetch arbiter.
package tmnt_rom_pkg;

  typedef enum logic [1:0] {
    CL_TILES = 2'd0,
    CL_SPR   = 2'd1,
    CL_M68K  = 2'd2,
    CL_THEME = 2'd3
  } client_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int          NUM_CLIENTS    = 4;
  localparam logic [25:0] TILES_BASE_DEF = 26'h0000000;
  localparam logic [25:0] SPR_BASE_DEF   = 26'h0100000;
  localparam logic [25:0] M68K_BASE_DEF  = 26'h0300000;
  localparam logic [25:0] THEME_BASE_DEF = 26'h0380000;

  // Half-word clients pack two 16-bit words per 32-bit SDRAM word, so bit 0
  // of their address selects the half and is dropped from the byte address.
  function automatic logic [25:0] form_addr(input logic [25:0] base,
                                            input logic [18:0] word,
                                            input logic        half_words);
    logic [25:0] offs;
    if (half_words) offs = {6'd0, word[18:1], 2'b00};
    else            offs = {5'd0, word, 2'b00};
    return base + offs;
  endfunction

endpackage

// File: rtl/rom_arb_slot.sv
// One client slot: pending flag, latched address and sticky overrun flag.
// A new request always wins over a same-cycle clear.
module rom_arb_slot
  import tmnt_rom_pkg::*;
#(
  parameter logic [25:0] BASE       = 26'h0000000,
  parameter bit          HALF_WORDS = 1'b0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        req,
  input  logic [18:0] addr,
  input  logic        clear,
  output logic        pending,
  output logic [25:0] byte_addr,
  output logic        half,
  output logic        overrun
);

  logic        pending_reg;
  logic [18:0] addr_reg;
  logic        overrun_reg;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pending_reg <= 1'b0;
      addr_reg    <= '0;
      overrun_reg <= 1'b0;
    end else if (req) begin
      pending_reg <= 1'b1;
      addr_reg    <= addr;
      if (pending_reg) overrun_reg <= 1'b1;
    end else if (clear) begin
      pending_reg <= 1'b0;
    end
  end

  assign pending   = pending_reg;
  assign overrun   = overrun_reg;
  assign byte_addr = form_addr(BASE, addr_reg, HALF_WORDS);
  assign half      = HALF_WORDS ? addr_reg[0] : 1'b0;

endmodule

// File: rtl/tmnt_rom_arbiter.sv
// Merges the tile, sprite, 68k and theme ROM fetch streams onto one SDRAM
// request/ack port with fixed priority and per-client data holding registers.
module tmnt_rom_arbiter
  import tmnt_rom_pkg::*;
#(
  parameter logic [25:0] TILES_BASE = TILES_BASE_DEF,
  parameter logic [25:0] SPR_BASE   = SPR_BASE_DEF,
  parameter logic [25:0] M68K_BASE  = M68K_BASE_DEF,
  parameter logic [25:0] THEME_BASE = THEME_BASE_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        tiles_rom_req,
  input  logic [17:0] tiles_rom_addr,
  output logic [31:0] tiles_rom_dout,
  input  logic        spr_rom_req,
  input  logic [18:0] spr_rom_addr,
  output logic [31:0] spr_rom_dout,
  input  logic        m68k_rom_req,
  input  logic [17:0] m68k_rom_addr,
  output logic [15:0] m68k_rom_dout,
  output logic        sdram_dtack,
  input  logic        theme_rom_req,
  input  logic [17:0] theme_rom_addr,
  output logic [31:0] theme_rom_dout,
  output logic        sdram_req,
  output logic [25:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic [31:0] sdram_dout,
  output logic [3:0]  overrun
);

  localparam logic [3:0][25:0] BASES = {THEME_BASE, M68K_BASE, SPR_BASE, TILES_BASE};

  logic [3:0]  req_vec;
  logic [3:0]  clear_vec;
  logic [3:0]  pending_vec;
  logic [3:0]  half_vec;
  logic [18:0] addr_vec      [NUM_CLIENTS];
  logic [25:0] byte_addr_vec [NUM_CLIENTS];

  assign req_vec     = {theme_rom_req, m68k_rom_req, spr_rom_req, tiles_rom_req};
  assign addr_vec[0] = {1'b0, tiles_rom_addr};
  assign addr_vec[1] = spr_rom_addr;
  assign addr_vec[2] = {1'b0, m68k_rom_addr};
  assign addr_vec[3] = {1'b0, theme_rom_addr};

  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_slot
    rom_arb_slot #(
      .BASE       (BASES[gi]),
      .HALF_WORDS (gi == int'(CL_M68K))
    ) u_slot (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .req       (req_vec[gi]),
      .addr      (addr_vec[gi]),
      .clear     (clear_vec[gi]),
      .pending   (pending_vec[gi]),
      .byte_addr (byte_addr_vec[gi]),
      .half      (half_vec[gi]),
      .overrun   (overrun[gi])
    );
  end

  state_t      state_reg, state_next;
  client_t     grant_reg, grant_next, pick;
  logic        half_reg, half_next;
  logic        sdram_req_reg, sdram_req_next;
  logic [25:0] sdram_addr_reg, sdram_addr_next;
  logic        ack_take;

  always_comb begin
    if      (pending_vec[0]) pick = CL_TILES;
    else if (pending_vec[1]) pick = CL_SPR;
    else if (pending_vec[2]) pick = CL_M68K;
    else                     pick = CL_THEME;
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    half_next       = half_reg;
    sdram_req_next  = sdram_req_reg;
    sdram_addr_next = sdram_addr_reg;
    ack_take        = 1'b0;
    clear_vec       = 4'd0;
    case (state_reg)
      ST_IDLE: begin
        if (|pending_vec) begin
          grant_next      = pick;
          half_next       = half_vec[pick];
          sdram_addr_next = byte_addr_vec[pick];
          sdram_req_next  = 1'b1;
          state_next      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (sdram_ack) begin
          ack_take       = 1'b1;
          clear_vec      = 4'd1 << grant_reg;
          sdram_req_next = 1'b0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= CL_TILES;
      half_reg       <= 1'b0;
      sdram_req_reg  <= 1'b0;
      sdram_addr_reg <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      half_reg       <= half_next;
      sdram_req_reg  <= sdram_req_next;
      sdram_addr_reg <= sdram_addr_next;
    end
  end

  // A fresh 68k request keeps DTACK low even if the previous fetch acks now.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tiles_rom_dout <= '0;
      spr_rom_dout   <= '0;
      m68k_rom_dout  <= '0;
      theme_rom_dout <= '0;
      sdram_dtack    <= 1'b1;
    end else begin
      if (ack_take) begin
        case (grant_reg)
          CL_TILES: tiles_rom_dout <= sdram_dout;
          CL_SPR:   spr_rom_dout   <= sdram_dout;
          CL_M68K:  m68k_rom_dout  <= half_reg ? sdram_dout[31:16] : sdram_dout[15:0];
          default:  theme_rom_dout <= sdram_dout;
        endcase
      end
      if (m68k_rom_req)                          sdram_dtack <= 1'b0;
      else if (ack_take && grant_reg == CL_M68K) sdram_dtack <= 1'b1;
    end
  end

  assign sdram_req  = sdram_req_reg;
  assign sdram_addr = sdram_addr_reg;

endmodule

// File: tb/tb_tmnt_rom_arbiter.sv
// Directed and randomized checks of tmnt_rom_arbiter against a
// transaction-level reference model with a randomized SDRAM responder.
module tb_tmnt_rom_arbiter;

  localparam logic [25:0] TB_TILES_BASE = 26'h0000000;
  localparam logic [25:0] TB_SPR_BASE   = 26'h0100000;
  localparam logic [25:0] TB_M68K_BASE  = 26'h0300000;
  localparam logic [25:0] TB_THEME_BASE = 26'h0380000;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        tiles_rom_req = 1'b0, spr_rom_req = 1'b0, m68k_rom_req = 1'b0, theme_rom_req = 1'b0;
  logic [17:0] tiles_rom_addr = '0, m68k_rom_addr = '0, theme_rom_addr = '0;
  logic [18:0] spr_rom_addr = '0;
  logic [31:0] tiles_rom_dout, spr_rom_dout, theme_rom_dout;
  logic [15:0] m68k_rom_dout;
  logic        sdram_dtack, sdram_req;
  logic [25:0] sdram_addr;
  logic        sdram_ack = 1'b0;
  logic [31:0] sdram_dout = '0;
  logic [3:0]  overrun;

  tmnt_rom_arbiter dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .tiles_rom_req  (tiles_rom_req),
    .tiles_rom_addr (tiles_rom_addr),
    .tiles_rom_dout (tiles_rom_dout),
    .spr_rom_req    (spr_rom_req),
    .spr_rom_addr   (spr_rom_addr),
    .spr_rom_dout   (spr_rom_dout),
    .m68k_rom_req   (m68k_rom_req),
    .m68k_rom_addr  (m68k_rom_addr),
    .m68k_rom_dout  (m68k_rom_dout),
    .sdram_dtack    (sdram_dtack),
    .theme_rom_req  (theme_rom_req),
    .theme_rom_addr (theme_rom_addr),
    .theme_rom_dout (theme_rom_dout),
    .sdram_req      (sdram_req),
    .sdram_addr     (sdram_addr),
    .sdram_ack      (sdram_ack),
    .sdram_dout     (sdram_dout),
    .overrun        (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // reference model state
  bit          model_on = 1'b0;
  bit          auto_sdram = 1'b0;
  bit          out_f [4];
  logic [25:0] exp_addr [4];
  bit          exp_half [4];
  int          pulse_cyc [4];
  logic [31:0] mdl_dout [4];
  bit          ack_hit = 1'b0;
  int          ack_cl = 0;
  bit          ack_was_out = 1'b0;
  logic [25:0] ack_addr = '0, ack_exp_addr = '0;
  int          ack_lat = 0;
  logic        prev_req = 1'b0;
  logic [25:0] addr_seen = '0;
  bit          armed = 1'b0;
  int          lat = 0;
  int          fetches = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [25:0] a);
    return {a[15:0], ~a[25:10]} ^ 32'h5A5A3C3C;
  endfunction

  function automatic int decode(input logic [25:0] a);
    if (a < TB_SPR_BASE)   return 0;
    if (a < TB_M68K_BASE)  return 1;
    if (a < TB_THEME_BASE) return 2;
    return 3;
  endfunction

  function automatic logic [25:0] model_addr(input int c, input logic [18:0] w);
    logic [31:0] t;
    case (c)
      0:       t = 32'(TB_TILES_BASE) + 32'(w) * 4;
      1:       t = 32'(TB_SPR_BASE)   + 32'(w) * 4;
      2:       t = 32'(TB_M68K_BASE)  + (32'(w) / 2) * 4;
      default: t = 32'(TB_THEME_BASE) + 32'(w) * 4;
    endcase
    return t[25:0];
  endfunction

  task automatic model_edge();
    logic [3:0]  r;
    logic [18:0] w [4];
    if (sdram_ack) begin
      ack_hit      = 1'b1;
      ack_cl       = decode(addr_seen);
      ack_addr     = addr_seen;
      ack_exp_addr = exp_addr[ack_cl];
      ack_was_out  = out_f[ack_cl];
      ack_lat      = cycle - pulse_cyc[ack_cl] + 1;
      out_f[ack_cl] = 1'b0;
      if (ack_cl == 2) mdl_dout[2] = {16'h0, exp_half[2] ? sdram_dout[31:16] : sdram_dout[15:0]};
      else             mdl_dout[ack_cl] = sdram_dout;
    end
    r = {theme_rom_req, m68k_rom_req, spr_rom_req, tiles_rom_req};
    w[0] = {1'b0, tiles_rom_addr};
    w[1] = spr_rom_addr;
    w[2] = {1'b0, m68k_rom_addr};
    w[3] = {1'b0, theme_rom_addr};
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        out_f[i]     = 1'b1;
        exp_addr[i]  = model_addr(i, w[i]);
        exp_half[i]  = w[i][0];
        pulse_cyc[i] = cycle;
      end
    end
  endtask

  task automatic model_check();
    int g, e;
    if (ack_hit) begin
      ack_hit = 1'b0;
      fetches++;
      chk("ack_client_pending", 32'(ack_was_out), 32'd1);
      chk("fetch_addr", 32'(ack_addr), 32'(ack_exp_addr));
      if (ack_cl < 2) chk("video_latency_le28", 32'(ack_lat <= 28), 32'd1);
      $display("fetch client=%0d addr=%h latency=%0d", ack_cl, ack_addr, ack_lat);
    end
    if (sdram_req && !prev_req) begin
      g = decode(sdram_addr);
      e = 4;
      for (int i = 3; i >= 0; i--) if (out_f[i] && pulse_cyc[i] <= cycle - 1) e = i;
      chk("grant_priority", 32'(g), 32'(e));
    end
    prev_req  = sdram_req;
    addr_seen = sdram_addr;
    chk("dtack", 32'(sdram_dtack), 32'(!out_f[2]));
    chk("tiles_dout", tiles_rom_dout, mdl_dout[0]);
    chk("spr_dout", spr_rom_dout, mdl_dout[1]);
    chk("m68k_dout", {16'h0, m68k_rom_dout}, mdl_dout[2]);
    chk("theme_dout", theme_rom_dout, mdl_dout[3]);
  endtask

  task automatic responder();
    if (armed) begin
      lat--;
      if (lat == 0) begin
        sdram_ack  = 1'b1;
        sdram_dout = mem_data(sdram_addr);
        armed      = 1'b0;
      end
    end else if (sdram_req) begin
      armed = 1'b1;
      lat   = int'($urandom_range(1, 10));
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    cycle++;
    if (model_on) model_edge();
    @(negedge clk_sys);
    tiles_rom_req = 1'b0; spr_rom_req = 1'b0; m68k_rom_req = 1'b0; theme_rom_req = 1'b0;
    sdram_ack = 1'b0;
    if (model_on) model_check();
    if (auto_sdram) responder();
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    tiles_rom_req = 1'b0; spr_rom_req = 1'b0; m68k_rom_req = 1'b0; theme_rom_req = 1'b0;
    sdram_ack = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_req", 32'(sdram_req), 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_dtack", 32'(sdram_dtack), 32'd1);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_tiles_dout", tiles_rom_dout, 32'd0);
    chk("rst_m68k_dout", 32'(m68k_rom_dout), 32'd0);
    $display("reset state checked");

    // single tile fetch
    tiles_rom_addr = 18'h00010; tiles_rom_req = 1'b1; step();
    chk("t1_req_not_yet", 32'(sdram_req), 32'd0);
    step();
    chk("t1_req", 32'(sdram_req), 32'd1);
    chk("t1_addr", 32'(sdram_addr), 32'h0000040);
    repeat (5) step();
    sdram_ack = 1'b1; sdram_dout = 32'hDEADBEEF; step();
    chk("t1_dout", tiles_rom_dout, 32'hDEADBEEF);
    chk("t1_req_drop", 32'(sdram_req), 32'd0);
    $display("tiles fetch addr=18'h00010 dout=%h", tiles_rom_dout);

    // single 68k fetch, upper half
    m68k_rom_addr = 18'h00003; m68k_rom_req = 1'b1; step();
    chk("t2_dtack_low", 32'(sdram_dtack), 32'd0);
    step();
    chk("t2_addr", 32'(sdram_addr), 32'h0300004);
    repeat (3) step();
    sdram_ack = 1'b1; sdram_dout = 32'h12345678; step();
    chk("t2_dout", 32'(m68k_rom_dout), 32'h1234);
    chk("t2_dtack_high", 32'(sdram_dtack), 32'd1);
    $display("m68k fetch addr=18'h00003 dout=%h", m68k_rom_dout);

    // simultaneous tiles + m68k: tiles first
    tiles_rom_addr = 18'h00020; m68k_rom_addr = 18'h00010;
    tiles_rom_req = 1'b1; m68k_rom_req = 1'b1; step();
    step();
    chk("t3_first_addr", 32'(sdram_addr), 32'h0000080);
    chk("t3_dtack0", 32'(sdram_dtack), 32'd0);
    repeat (2) step();
    sdram_ack = 1'b1; sdram_dout = 32'h11112222; step();
    chk("t3_tiles_dout", tiles_rom_dout, 32'h11112222);
    chk("t3_req_gap", 32'(sdram_req), 32'd0);
    chk("t3_dtack1", 32'(sdram_dtack), 32'd0);
    step();
    chk("t3_second_req", 32'(sdram_req), 32'd1);
    chk("t3_second_addr", 32'(sdram_addr), 32'h0300020);
    chk("t3_dtack2", 32'(sdram_dtack), 32'd0);
    step();
    sdram_ack = 1'b1; sdram_dout = 32'hAAAA5555; step();
    chk("t3_m68k_dout", 32'(m68k_rom_dout), 32'h5555);
    chk("t3_dtack3", 32'(sdram_dtack), 32'd1);
    $display("priority tiles-before-m68k done");

    // spr overrun while bus busy with tiles
    tiles_rom_addr = 18'h00001; tiles_rom_req = 1'b1; step();
    spr_rom_addr = 19'h1; spr_rom_req = 1'b1; step();
    spr_rom_addr = 19'h2; spr_rom_req = 1'b1; step();
    chk("t4_overrun", 32'(overrun), 32'b0010);
    chk("t4_tiles_addr", 32'(sdram_addr), 32'h0000004);
    sdram_ack = 1'b1; sdram_dout = 32'h01020304; step();
    step();
    chk("t4_spr_req", 32'(sdram_req), 32'd1);
    chk("t4_spr_addr", 32'(sdram_addr), 32'(TB_SPR_BASE + 26'h8));
    sdram_ack = 1'b1; sdram_dout = 32'h55667788; step();
    chk("t4_spr_dout", spr_rom_dout, 32'h55667788);
    repeat (3) step();
    chk("t4_single_fetch", 32'(sdram_req), 32'd0);
    $display("spr overrun fetch addr=%h", TB_SPR_BASE + 26'h8);

    // tiles pulse coinciding with its own ack
    tiles_rom_addr = 18'h00005; tiles_rom_req = 1'b1; step();
    step();
    tiles_rom_addr = 18'h00006; tiles_rom_req = 1'b1;
    sdram_ack = 1'b1; sdram_dout = 32'hCAFEF00D; step();
    chk("t6_dout", tiles_rom_dout, 32'hCAFEF00D);
    step();
    chk("t6_refetch_req", 32'(sdram_req), 32'd1);
    chk("t6_refetch_addr", 32'(sdram_addr), 32'h0000018);
    sdram_ack = 1'b1; sdram_dout = 32'h0BADF00D; step();
    chk("t6_dout2", tiles_rom_dout, 32'h0BADF00D);
    $display("tiles pulse-with-ack refetch done");

    // m68k pulse coinciding with m68k ack keeps DTACK low
    m68k_rom_addr = 18'h00004; m68k_rom_req = 1'b1; step();
    step();
    m68k_rom_addr = 18'h00005; m68k_rom_req = 1'b1;
    sdram_ack = 1'b1; sdram_dout = 32'h87654321; step();
    chk("t7_dtack_held", 32'(sdram_dtack), 32'd0);
    chk("t7_dout", 32'(m68k_rom_dout), 32'h4321);
    step();
    chk("t7_addr", 32'(sdram_addr), 32'h0300008);
    sdram_ack = 1'b1; sdram_dout = 32'h0F0F1E1E; step();
    chk("t7_dout2", 32'(m68k_rom_dout), 32'h0F0F);
    chk("t7_dtack", 32'(sdram_dtack), 32'd1);
    $display("m68k pulse-with-ack done");

    // reset while busy, stale ack afterwards
    m68k_rom_addr = 18'h00007; m68k_rom_req = 1'b1; step();
    step();
    chk("t5_busy", 32'(sdram_req), 32'd1);
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    sdram_ack = 1'b1; sdram_dout = 32'hFFFFFFFF; step();
    chk("t5_req", 32'(sdram_req), 32'd0);
    chk("t5_m68k_dout", 32'(m68k_rom_dout), 32'd0);
    chk("t5_tiles_dout", tiles_rom_dout, 32'd0);
    chk("t5_dtack", 32'(sdram_dtack), 32'd1);
    repeat (2) step();
    chk("t5_req_later", 32'(sdram_req), 32'd0);
    $display("reset mid-transfer done");

    // randomized traffic with 32-clock video cadence
    do_reset();
    for (int i = 0; i < 4; i++) begin
      out_f[i] = 1'b0; exp_addr[i] = '0; exp_half[i] = 1'b0; pulse_cyc[i] = 0; mdl_dout[i] = '0;
    end
    prev_req = 1'b0; addr_seen = '0; armed = 1'b0;
    model_on = 1'b1; auto_sdram = 1'b1;
    for (int k = 0; k < 2048; k++) begin
      if (k % 32 == 0 && !out_f[0]) begin
        tiles_rom_addr = 18'($urandom()); tiles_rom_req = 1'b1;
      end
      if (k % 32 == 16 && !out_f[1]) begin
        spr_rom_addr = 19'($urandom()); spr_rom_req = 1'b1;
      end
      if ($urandom_range(0, 7) == 0 && !out_f[2]) begin
        m68k_rom_addr = 18'($urandom()); m68k_rom_req = 1'b1;
      end
      if ($urandom_range(0, 5) == 0 && !out_f[3]) begin
        theme_rom_addr = 18'($urandom()); theme_rom_req = 1'b1;
      end
      step();
    end
    repeat (60) step();
    for (int i = 0; i < 4; i++) chk("drained", 32'(out_f[i]), 32'd0);
    chk("rand_no_overrun", 32'(overrun), 32'd0);
    chk("rand_fetches_seen", 32'(fetches > 100), 32'd1);
    model_on = 1'b0; auto_sdram = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmnt_rom_arbiter.md
# tmnt_rom_arbiter

Arbitrates the four ROM fetch streams leaving the TMNT/MIA core: tiles, sprites, 68k program, and theme/sample. Each is merged into one request/acknowledge port of the shared SDRAM controller. The block sits between the core and the SDRAM controller. It latches each client's address on its request pulse, serialises the fetches by fixed priority, and returns data to per-client holding registers. It also produces the `sdram_dtack` wait signal the core ANDs into the 68k DTACK.

## Interface
Parameters:
- TILES_BASE, 26'h0000000, byte base of tile ROM in SDRAM
- SPR_BASE, 26'h0100000, byte base of sprite ROM
- M68K_BASE, 26'h0300000, byte base of 68k program ROM
- THEME_BASE, 26'h0380000, byte base of theme/sample ROM

Ports:
- clk_sys  in  1  96 MHz system clock
- reset  in  1  asynchronous, active-high
- tiles_rom_req  in  1  one-cycle fetch pulse
- tiles_rom_addr  in  18  32-bit word address
- tiles_rom_dout  out  32  returned tile data
- spr_rom_req  in  1  one-cycle fetch pulse
- spr_rom_addr  in  19  32-bit word address
- spr_rom_dout  out  32  returned sprite data
- m68k_rom_req  in  1  one-cycle fetch pulse
- m68k_rom_addr  in  18  16-bit word address
- m68k_rom_dout  out  16  returned program word
- sdram_dtack  out  1  low while a 68k fetch is outstanding
- theme_rom_req  in  1  one-cycle fetch pulse
- theme_rom_addr  in  18  32-bit word address
- theme_rom_dout  out  32  returned theme data
- sdram_req  out  1  request level to the SDRAM controller
- sdram_addr  out  26  byte address, 4-byte aligned
- sdram_ack  in  1  one-cycle pulse; `sdram_dout` is valid in the same cycle
- sdram_dout  in  32  read data
- overrun  out  4  sticky flags {theme, m68k, spr, tiles}: a new request arrived while the previous one was still pending

## Operation
- Per-client state: a `pending` flag and an address register, both set on the client's request pulse.
  - A request pulse while already pending overwrites the address and sets that client's `overrun` bit.
- Byte address formation, with arithmetic truncated to 26 bits:
  - tiles = TILES_BASE + {addr, 2'b00}
  - sprites = SPR_BASE + {addr, 2'b00}
  - theme = THEME_BASE + {addr, 2'b00}
  - m68k = M68K_BASE + {addr[17:1], 2'b00}; the half-word is selected by addr[0] (0 → [15:0], 1 → [31:16]).
- Fixed priority: tiles > sprites > m68k > theme. The decision is taken only in IDLE; there is no preemption.
- FSM states:
  - IDLE: if any client is pending, latch the grant index, drive `sdram_addr`, set `sdram_req` = 1 → BUSY.
  - BUSY: hold `sdram_req` and `sdram_addr` stable. On `sdram_ack`: load the granted client's dout, clear its `pending`, drop `sdram_req` → IDLE.
- Simultaneous request pulse and `sdram_ack` for the same client: the pulse wins. `pending` stays set with the new address, and the data just received is still delivered.
- `sdram_ack` in IDLE is ignored.
- `sdram_dtack`:
  - cleared the cycle after `m68k_rom_req`;
  - set the cycle after the m68k ack;
  - remains 0 if a new m68k request coincides with the ack.
- Reset values:
  - all `pending` flags 0, FSM in IDLE;
  - `sdram_req` 0, `sdram_addr` 0;
  - all dout registers 0;
  - `sdram_dtack` 1, `overrun` 0.
- Reset mid-transfer abandons the fetch. A stale ack after reset is ignored.

## Timing
- Request pulse at cycle N: `pending` is visible at N+1. If the FSM is IDLE, `sdram_req` is high at N+2.
- Ack at cycle M: dout register and `sdram_dtack` update at M+1. IDLE is entered at M+1, so the next grant's `sdram_req` is high at M+2.
- Video clients pulse every 32 clocks. A tile or sprite fetch must complete in ≤ 28 clocks from its pulse, assuming the SDRAM controller acks within 12 clocks.
- The dout registers hold their value until the next ack for that client.

## Structure
- Shared package `tmnt_rom_pkg`:
  - client index enum (CL_TILES=0, CL_SPR=1, CL_M68K=2, CL_THEME=3);
  - base address localparams;
  - address-forming function.
- One sub-module `rom_arb_slot`, instantiated ×4:
  - holds `pending`, the address register and the overrun bit;
  - inputs are req, addr and clear;
  - returns pending and the formed byte address.
- The FSM, priority encoder and dout routing live in the top level.

## Test plan
- tiles_rom_addr=18'h00010, pulse; ack after 6 cycles with 32'hDEADBEEF → `sdram_addr`=26'h0000040; tiles_rom_dout=32'hDEADBEEF at ack+1.
- m68k_rom_addr=18'h00003, pulse → `sdram_dtack`=0 next cycle, `sdram_addr`=26'h0300004; ack with 32'h12345678 → m68k_rom_dout=16'h1234, `sdram_dtack`=1 at ack+1.
- m68k and tiles pulse in the same cycle → tiles granted first; m68k granted at tiles-ack+1; `sdram_dtack` stays 0 until the m68k ack.
- Second spr pulse while spr pending, with spr_rom_addr changing 19'h1 → 19'h2 → one fetch at SPR_BASE+8; overrun[1]=1.
- Assert reset while BUSY, then pulse `sdram_ack` after release → `sdram_req`=0, no dout changes, `sdram_dtack`=1.
- Theme request with the 32-clock tiles/spr cadence running → theme is served in gaps only, and every video fetch meets the 28-clock bound.
